// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between N requesters and the round-robin arbiter.
interface rr_grant_arbiter_if #(parameter int N = 8);
    localparam int IDXW = N > 1 ? $clog2(N) : 1;
    logic [N-1:0]    Req;
    logic            GntReady;
    logic            Flush;
    logic            GntValid;
    logic [N-1:0]    Gnt;
    logic [IDXW-1:0] GntIdx;
    modport master (output Req, GntReady, Flush, input GntValid, Gnt, GntIdx);
    modport slave (input Req, GntReady, Flush, output GntValid, Gnt, GntIdx);
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin arbiter holding a one-hot grant until accepted or flushed.
module rr_grant_arbiter_poh #(parameter int N = 8) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_onehot
);
    assign o_onehot = i_req & (~i_req + N'(1));
endmodule

module rr_grant_arbiter #(parameter int N = 8) (
    input logic           clk,
    input logic           reset,
    rr_grant_arbiter_if.slave bus
);
    localparam int IDXW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, r_last, w_gnt_nxt, w_last_nxt;
    logic [N-1:0]    w_base, w_mask, w_pick_m, w_pick_r, w_pick;
    logic [IDXW-1:0] w_idx;
    logic            w_accept;
    // On accept the mask must already reflect the grant being retired this cycle.
    assign w_accept = (r_state == GRANT) && bus.GntReady && !bus.Flush;
    assign w_base   = w_accept ? r_gnt : r_last;
    assign w_mask   = ~(w_base | (w_base - N'(1)));
    rr_grant_arbiter_poh #(.N(N)) u_poh_masked (.i_req(bus.Req & w_mask), .o_onehot(w_pick_m));
    rr_grant_arbiter_poh #(.N(N)) u_poh_raw (.i_req(bus.Req), .o_onehot(w_pick_r));
    assign w_pick = |w_pick_m ? w_pick_m : w_pick_r;
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        if (r_state == IDLE) begin
            if (!bus.Flush && |bus.Req) begin
                w_gnt_nxt   = w_pick;
                w_state_nxt = GRANT;
            end
        end else if (bus.Flush) begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
        end else if (bus.GntReady) begin
            w_last_nxt  = r_gnt;
            w_gnt_nxt   = w_pick;
            w_state_nxt = |w_pick ? GRANT : IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= N'(1) << (N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++)
            if (r_gnt[i]) w_idx = w_idx | IDXW'(i);
    end
    assign bus.GntValid = (r_state == GRANT);
    assign bus.Gnt      = r_gnt;
    assign bus.GntIdx   = w_idx;
    assert property (@(posedge clk) disable iff (reset)
        $onehot0(r_gnt) && (bus.GntValid == |r_gnt) &&
        (r_gnt == (bus.GntValid ? N'(1) << w_idx : N'(0))));
endmodule
